// File: rtl/tree_op_scheduler.sv
// Issue scheduler for the SRAM PIFO ring: classifies each port's task against tree
// occupancy, arbitrates round-robin per root RPU and issues at most one registered op per RPU.
module tree_op_scheduler #(
   parameter int PTW      = 16,
   parameter int MTW      = 0,
   parameter int LEVEL    = 4,
   parameter int TREE_NUM = 4,
   parameter int TREE_CAP = 30,
   parameter int GAP      = 2,
   parameter int TNB      = $clog2(TREE_NUM),
   parameter int DW       = MTW + PTW
) (
   input  logic                 i_clk,
   input  logic                 i_arst_n,
   input  logic [LEVEL-1:0]     i_task_valid,
   input  logic [LEVEL-1:0]     i_task_push,
   input  logic [LEVEL*TNB-1:0] i_task_tree_id,
   input  logic [LEVEL*DW-1:0]  i_task_data,
   output logic [LEVEL-1:0]     o_task_ready,
   input  logic [LEVEL-1:0]     i_rpu_busy,
   output logic [LEVEL-1:0]     o_rpu_push,
   output logic [LEVEL-1:0]     o_rpu_pop,
   output logic [LEVEL*TNB-1:0] o_rpu_tree_id,
   output logic [LEVEL*DW-1:0]  o_rpu_push_data,
   output logic [LEVEL-1:0]     o_drop_full,
   output logic [LEVEL-1:0]     o_pop_empty
);
   localparam int LB  = $clog2(LEVEL);
   localparam int OCW = $clog2(TREE_CAP + 1);
   localparam int CW  = 4;

   logic [OCW-1:0]      occ_reg    [TREE_NUM];
   logic [CW-1:0]       cool_reg   [TREE_NUM];
   logic [LB-1:0]       rr_ptr_reg [LEVEL];

   logic [TNB-1:0]      port_tree  [LEVEL];
   logic [LB-1:0]       port_rpu   [LEVEL];
   logic [LEVEL-1:0]    rej_full;
   logic [LEVEL-1:0]    rej_empty;
   logic [LEVEL-1:0]    eligible;
   logic [LEVEL-1:0]    port_grant;

   logic [LEVEL-1:0]    rpu_gnt;
   logic [LB-1:0]       rpu_win    [LEVEL];

   logic [TREE_NUM-1:0] tree_gnt;
   logic [TREE_NUM-1:0] tree_is_push;

   logic [LEVEL-1:0]    push_next;
   logic [LEVEL-1:0]    pop_next;
   logic [LEVEL*TNB-1:0] tid_next;
   logic [LEVEL*DW-1:0] data_next;

   logic [LEVEL-1:0]    push_reg;
   logic [LEVEL-1:0]    pop_reg;
   logic [LEVEL*TNB-1:0] tid_reg;
   logic [LEVEL*DW-1:0] data_reg;
   logic [LEVEL-1:0]    drop_reg;
   logic [LEVEL-1:0]    empty_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LEVEL; gi++) begin : g_port
         logic [OCW-1:0] occ_t;
         logic           cand;
         assign port_tree[gi]  = i_task_tree_id[gi*TNB +: TNB];
         assign port_rpu[gi]   = port_tree[gi][LB-1:0];
         assign occ_t          = occ_reg[port_tree[gi]];
         assign rej_full[gi]   = i_task_valid[gi] &  i_task_push[gi] & (occ_t == OCW'(TREE_CAP));
         assign rej_empty[gi]  = i_task_valid[gi] & ~i_task_push[gi] & (occ_t == '0);
         assign cand           = i_task_valid[gi] & ~rej_full[gi] & ~rej_empty[gi];
         assign eligible[gi]   = cand & (cool_reg[port_tree[gi]] == '0) & ~i_rpu_busy[port_rpu[gi]];
         // A port can only ever be granted by its tree's root RPU.
         assign port_grant[gi] = rpu_gnt[port_rpu[gi]] & (rpu_win[port_rpu[gi]] == LB'(gi));
      end

      for (gi = 0; gi < LEVEL; gi++) begin : g_rpu
         logic [LEVEL-1:0] req;
         logic             found;
         logic [LB-1:0]    win;
         logic [LB-1:0]    idx;

         always_comb begin
            req = '0;
            for (int p = 0; p < LEVEL; p++) begin
               req[p] = eligible[p] & (port_rpu[p] == LB'(gi));
            end
         end

         // First requester at or after the pointer wins; LB-bit wrap gives mod LEVEL.
         always_comb begin
            found = 1'b0;
            win   = '0;
            idx   = '0;
            for (int k = 0; k < LEVEL; k++) begin
               idx = rr_ptr_reg[gi] + LB'(k);
               if (!found && req[idx]) begin
                  found = 1'b1;
                  win   = idx;
               end
            end
         end

         assign rpu_gnt[gi]              = found;
         assign rpu_win[gi]              = win;
         assign push_next[gi]            = found &  i_task_push[win];
         assign pop_next[gi]             = found & ~i_task_push[win];
         assign tid_next[gi*TNB +: TNB]  = found ? port_tree[win] : '0;
         assign data_next[gi*DW +: DW]   = (found & i_task_push[win]) ? i_task_data[win*DW +: DW] : '1;
      end

      for (gi = 0; gi < TREE_NUM; gi++) begin : g_tree
         localparam int R = gi % LEVEL;
         assign tree_gnt[gi]     = rpu_gnt[R] & (port_tree[rpu_win[R]] == TNB'(gi));
         assign tree_is_push[gi] = i_task_push[rpu_win[R]];
      end
   endgenerate

   assign o_task_ready = rej_full | rej_empty | port_grant;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int t = 0; t < TREE_NUM; t++) begin
            occ_reg[t]  <= '0;
            cool_reg[t] <= '0;
         end
         for (int r = 0; r < LEVEL; r++) begin
            rr_ptr_reg[r] <= '0;
         end
      end else begin
         for (int t = 0; t < TREE_NUM; t++) begin
            if (tree_gnt[t]) begin
               occ_reg[t]  <= tree_is_push[t] ? occ_reg[t] + OCW'(1) : occ_reg[t] - OCW'(1);
               cool_reg[t] <= CW'(GAP);
            end else if (cool_reg[t] != '0) begin
               cool_reg[t] <= cool_reg[t] - CW'(1);
            end
         end
         for (int r = 0; r < LEVEL; r++) begin
            if (rpu_gnt[r]) begin
               rr_ptr_reg[r] <= rpu_win[r] + LB'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         push_reg  <= '0;
         pop_reg   <= '0;
         tid_reg   <= '0;
         data_reg  <= '1;
         drop_reg  <= '0;
         empty_reg <= '0;
      end else begin
         push_reg  <= push_next;
         pop_reg   <= pop_next;
         tid_reg   <= tid_next;
         data_reg  <= data_next;
         drop_reg  <= rej_full;
         empty_reg <= rej_empty;
      end
   end

   assign o_rpu_push      = push_reg;
   assign o_rpu_pop       = pop_reg;
   assign o_rpu_tree_id   = tid_reg;
   assign o_rpu_push_data = data_reg;
   assign o_drop_full     = drop_reg;
   assign o_pop_empty     = empty_reg;

endmodule
